// File: rtl/uart_tx_pkg.sv
// Shared UART framing constants and FSM state encoding, also used by the receive path.
package uart_tx_pkg;

    localparam int FRAME_BITS = 10;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } uart_state_t;

    // 8N1 frame with the start bit in bit 0 so it leaves the shifter first.
    function automatic logic [FRAME_BITS-1:0] make_frame(input logic [7:0] data);
        return {1'b1, data, 1'b0};
    endfunction

endpackage

// File: rtl/bit_shift10r.sv
// 10-bit right shifter, MSB filled with 1 on each shift, resets to all ones.
// Latency: load/shift take effect at the next rising edge.
// Backpressure: none; load has priority over shift.
module bit_shift10r
    import uart_tx_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  shift,
    input  logic [FRAME_BITS-1:0] in,
    output logic [FRAME_BITS-1:0] out
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '1;
        end else if (load) begin
            out <= in;
        end else if (shift) begin
            out <= {1'b1, out[FRAME_BITS-1:1]};
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: frames a byte and shifts it out LSB first at CLKS_PER_BIT.
// Latency: start bit on tx from the edge that accepts load; busy for 10*CLKS_PER_BIT cycles.
// Backpressure: load ignored while busy, except on the final stop-bit edge (back-to-back frames).
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in,
    input  logic       load,
    output logic       tx,
    output logic       busy
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]        BIT_LAST  = 4'(FRAME_BITS - 1);

    uart_state_t           state;
    logic [BAUD_W-1:0]     baud_cnt;
    logic [3:0]            bit_cnt;
    logic [FRAME_BITS-1:0] shift_dat;
    logic                  bit_end;
    logic                  frame_end;
    logic                  sr_load;

    assign bit_end   = (state == ST_SHIFT) && (baud_cnt == BAUD_LAST);
    assign frame_end = bit_end && (bit_cnt == BIT_LAST);
    // Reloading on the last stop-bit edge gives zero idle cycles between frames.
    assign sr_load   = load && ((state == ST_IDLE) || frame_end);

    bit_shift10r u_shift (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (sr_load),
        .shift (bit_end),
        .in    (make_frame(in)),
        .out   (shift_dat)
    );

    // The shifter idles at all ones, so its LSB is the line level in every state.
    assign tx = shift_dat[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (load) begin
                        state <= ST_SHIFT;
                        busy  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            if (!load) begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed timing checks plus a mid-bit sampling
// reference receiver fed by an expected-byte scoreboard.
module tb_uart_tx;

    localparam int CPB = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] in;
    logic       load;
    logic       tx;
    logic       busy;

    int         n_checks = 0;
    int         n_errors = 0;
    int         epoch    = 0;
    logic [7:0] exp_q[$];

    uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in),
        .load  (load),
        .tx    (tx),
        .busy  (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i >= 9) return 1'b1;
        return b[i-1];
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check("idle_timeout", 1, 0);
    endtask

    // One frame with optional mid-frame load attempts at cycles m1/m2 after acceptance.
    task automatic frame_test(input logic [7:0] b, input int m1, input int m2);
        int bcnt = 0;
        wait_idle();
        in   = b;
        load = 1'b1;
        @(negedge clk);
        exp_q.push_back(b);
        for (int cyc = 0; cyc < 10*CPB; cyc++) begin
            load = 1'b0;
            if (cyc % CPB == 0)
                check($sformatf("tx_%02h_bit%0d", b, cyc/CPB), tx, frame_bit(b, cyc/CPB));
            if (busy) bcnt++;
            if (cyc == m1 || cyc == m2) begin
                in   = 8'hFF;
                load = 1'b1;
            end
            @(negedge clk);
        end
        load = 1'b0;
        check($sformatf("busy_len_%02h", b), bcnt, 10*CPB);
        check($sformatf("busy_fall_%02h", b), busy, 0);
    endtask

    // Reference receiver: samples mid-bit, compares against the scoreboard.
    initial begin
        logic [7:0] data;
        logic       start_bit;
        logic       stop_bit;
        logic [7:0] exp_b;
        int         ep;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                ep = epoch;
                repeat (CPB/2) @(negedge clk);
                start_bit = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    data[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                stop_bit = tx;
                if (ep == epoch) begin
                    if (exp_q.size() == 0) begin
                        check("rx_unexpected_frame", {24'd0, data}, 32'hFFFF_FFFF);
                    end else begin
                        exp_b = exp_q.pop_front();
                        check("rx_start", start_bit, 0);
                        check("rx_byte", data, exp_b);
                        check("rx_stop", stop_bit, 1);
                    end
                end
            end
        end
    end

    initial begin
        int bad;
        int bcnt;
        int n;
        logic [7:0] b;

        rst_n = 1'b0;
        load  = 1'b0;
        in    = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;

        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("idle_50", bad, 0);

        frame_test(8'hA5, -1, -1);
        frame_test(8'h00, 5, 20);

        // Back-to-back with load held high.
        wait_idle();
        in   = 8'h55;
        load = 1'b1;
        @(negedge clk);
        exp_q.push_back(8'h55);
        exp_q.push_back(8'h3C);
        in   = 8'h3C;
        bcnt = 0;
        for (int cyc = 0; cyc < 20*CPB; cyc++) begin
            if (cyc == 10*CPB + 1) load = 1'b0;
            if (cyc % CPB == 0)
                check($sformatf("b2b_bit%0d", cyc/CPB), tx,
                      (cyc < 10*CPB) ? frame_bit(8'h55, cyc/CPB) : frame_bit(8'h3C, cyc/CPB - 10));
            if (busy) bcnt++;
            @(negedge clk);
        end
        load = 1'b0;
        check("b2b_busy_len", bcnt, 20*CPB);
        check("b2b_busy_fall", busy, 0);

        // Asynchronous reset mid-frame.
        wait_idle();
        in   = 8'h00;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        exp_q.push_back(8'h00);
        repeat (17) @(negedge clk);
        #1;
        rst_n = 1'b0;
        epoch++;
        exp_q.delete();
        #1;
        check("arst_tx", tx, 1);
        check("arst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        frame_test(8'h00, -1, -1);

        // Random bytes with random idle gaps.
        for (int f = 0; f < 1000; f++) begin
            wait_idle();
            repeat ($urandom_range(0, 3)) @(negedge clk);
            b    = 8'($urandom);
            in   = b;
            load = 1'b1;
            @(negedge clk);
            load = 1'b0;
            exp_q.push_back(b);
        end

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
